// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequential 2-to-4 decoder.
package decoder_pkg;

  localparam int CODE_W = 2;
  localparam int LINE_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One-hot decode of a code: code n raises line n.
  function automatic logic [LINE_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [LINE_W-1:0] res;
    res       = '0;
    res[code] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Combinational code -> one-hot line decode.
module decoder_2to4_core
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LINE_W-1:0] line
);

  assign line = onehot(code);

endmodule

// File: rtl/decoder_2to4_seq.sv
// Sequential 2-to-4 decoder: valid/ready code intake, one-hot line held for
// HOLD_CYCLES then GAP_CYCLES of all-off, with a one-entry pending buffer so
// codes stream without bubbles.
// Build option: DECODER_ACTIVE_LOW_EN makes out_line active-low (off = 4'b1111).
module decoder_2to4_seq
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [LINE_W-1:0] out_line,
  output logic              busy,
  output logic              done
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..255");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("GAP_CYCLES must be in 0..255");
  end

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [LINE_W-1:0] LINE_OFF = '1;
`else
  localparam logic [LINE_W-1:0] LINE_OFF = '0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic             HAS_GAP = (GAP_CYCLES > 0);
  localparam logic             HOLD_1  = (HOLD_CYCLES == 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                pend_valid;
  logic [CODE_W-1:0]   pend_code;
  logic [CODE_W-1:0]   next_code;
  logic [LINE_W-1:0]   dec_line;
  logic [LINE_W-1:0]   drive_line;
  logic                accept;
  logic                last;
  logic                exit_cyc;
  logic                load;

  // Ready depends only on the buffer register; held low during reset.
  assign in_ready  = !pend_valid && !rst;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == '0);
  assign busy      = (state != IDLE);

  // Exit cycle: final cycle of the hold/gap sequence, where the next code is chosen.
  assign exit_cyc  = (state == GAP && last) || (state == DRIVE && last && !HAS_GAP);
  assign load      = (state == IDLE && accept) || (exit_cyc && (pend_valid || accept));

  // Pending code has priority; it can only coexist with in_ready=0.
  assign next_code = pend_valid ? pend_code : in_code;

  decoder_2to4_core u_core (
    .code (next_code),
    .line (dec_line)
  );

`ifdef DECODER_ACTIVE_LOW_EN
  assign drive_line = ~dec_line;
`else
  assign drive_line = dec_line;
`endif

  // FSM, counter, pending buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
      out_line   <= LINE_OFF;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state      <= DRIVE;
        cnt        <= HOLD_LD;
        out_line   <= drive_line;
        done       <= HOLD_1;
        pend_valid <= 1'b0;
      end else begin
        case (state)
          DRIVE: begin
            if (!last) begin
              cnt  <= cnt - 1'b1;
              done <= (cnt == CNT_W'(1));
            end else if (HAS_GAP) begin
              state    <= GAP;
              cnt      <= GAP_LD;
              out_line <= LINE_OFF;
            end else begin
              state    <= IDLE;
              out_line <= LINE_OFF;
            end
          end
          GAP: begin
            if (!last) begin
              cnt <= cnt - 1'b1;
            end else begin
              state    <= IDLE;
              out_line <= LINE_OFF;
            end
          end
          default: begin
            out_line <= LINE_OFF;
          end
        endcase
        // Beats arriving mid-sequence wait in the buffer.
        if (accept) begin
          pend_valid <= 1'b1;
          pend_code  <= in_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_2to4_seq.sv
// Scoreboard bench for decoder_2to4_seq: two configurations (hold 4/gap 1 and
// hold 1/gap 0) driven with random valid/code traffic, checked per cycle
// against a schedule model (start = max(accept+1, prev_start+hold+gap)).
module tb_decoder_2to4_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [3:0] OFF = 4'hF;
  localparam bit ACT_LOW = 1'b1;
`else
  localparam logic [3:0] OFF = 4'h0;
  localparam bit ACT_LOW = 1'b0;
`endif

  typedef struct {
    int         acc;
    int         start;
    logic [1:0] code;
  } ent_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] line_of(input logic [1:0] code);
    logic [3:0] v;
    v = 4'(1 << code);
    return ACT_LOW ? ~v : v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int H = (g == 0) ? 4 : 1;
    localparam int G = (g == 0) ? 1 : 0;

    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic [3:0] out_line;
    logic       busy;
    logic       done;

    ent_t q[$];
    int   t = 0;
    int   last_start = -1000;
    bit   acc_prev = 1'b0;
    bit   pend_m = 1'b0;

    decoder_2to4_seq #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_code  (in_code),
      .out_line (out_line),
      .busy     (busy),
      .done     (done)
    );

    // Buffer is full in cycle tc iff some code was accepted earlier but has not started yet.
    function automatic bit model_ready(input int tc);
      foreach (q[i]) if (q[i].acc < tc && q[i].start > tc) return 1'b0;
      return 1'b1;
    endfunction

    // Driver: random offers, held until accepted; code may be reshuffled while blocked.
    initial begin
      in_valid = 1'b0;
      in_code  = 2'd0;
      forever begin
        @(posedge clk);
        #1;
        t++;
        if (rst) begin
          in_valid   = 1'b0;
          acc_prev   = 1'b0;
          pend_m     = 1'b0;
          last_start = -1000;
          q.delete();
        end else begin
          bit   r;
          ent_t e;
          r = model_ready(t);
          if (acc_prev) in_valid = 1'b0;
          if (!in_valid) begin
            if ($urandom_range(0, 3) != 0) begin
              in_valid = 1'b1;
              in_code  = 2'($urandom);
            end
          end else if (!r && $urandom_range(0, 2) == 0) begin
            in_code = 2'($urandom);
          end
          pend_m   = !r;
          acc_prev = in_valid && r;
          if (acc_prev) begin
            e.acc   = t;
            e.start = (t + 1 > last_start + H + G) ? t + 1 : last_start + H + G;
            e.code  = in_code;
            q.push_back(e);
            last_start = e.start;
          end
        end
      end
    end

    // Monitor: compare every output against the schedule, retire finished codes.
    always @(negedge clk) begin
      logic [3:0] el;
      bit         ed;
      bit         eb;
      if (rst) begin
        chk($sformatf("cfg%0d rst_line", g), out_line, OFF);
        chk($sformatf("cfg%0d rst_busy", g), {3'b0, busy}, 4'd0);
        chk($sformatf("cfg%0d rst_done", g), {3'b0, done}, 4'd0);
        chk($sformatf("cfg%0d rst_ready", g), {3'b0, in_ready}, 4'd0);
      end else begin
        el = OFF;
        ed = 1'b0;
        eb = 1'b0;
        foreach (q[i]) begin
          if (q[i].start <= t && t < q[i].start + H) begin
            el = line_of(q[i].code);
            if (t == q[i].start + H - 1) ed = 1'b1;
          end
          if (q[i].start <= t && t < q[i].start + H + G) eb = 1'b1;
        end
        chk($sformatf("cfg%0d line t=%0d", g, t), out_line, el);
        chk($sformatf("cfg%0d done t=%0d", g, t), {3'b0, done}, {3'b0, ed});
        chk($sformatf("cfg%0d busy t=%0d", g, t), {3'b0, busy}, {3'b0, eb});
        chk($sformatf("cfg%0d ready t=%0d", g, t), {3'b0, in_ready}, {3'b0, model_ready(t)});
        while (q.size() > 0 && q[0].start + H + G - 1 <= t) void'(q.pop_front());
      end
    end
  end

  // Sequencer: reset, random streaming, mid-operation reset, more streaming.
  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (400) @(posedge clk);

    n = 0;
    #2;
    while (!cfg[0].pend_m && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    total++;
    if (!cfg[0].pend_m) begin
      bad++;
      $display("FAIL pend_fill: buffer never observed full within %0d cycles", n);
    end

    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst cfg0 line", cfg[0].out_line, OFF);
    chk("mid_rst cfg0 ready", {3'b0, cfg[0].in_ready}, 4'd0);
    chk("mid_rst cfg0 busy", {3'b0, cfg[0].busy}, 4'd0);
    chk("mid_rst cfg1 line", cfg[1].out_line, OFF);
    chk("mid_rst cfg1 ready", {3'b0, cfg[1].in_ready}, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
